// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: the prediction word carried down the pipe,
// plus the branch target buffer entry layout used by branch_predictor.
package rv32i_types;

   // Prediction word produced in IF and carried with the instruction.
   typedef struct packed {
      logic        predicted;     // BTB hit for this PC
      logic        prediction;    // predicted direction (1 = taken)
      logic [31:0] brp_target;    // next fetch PC chosen by the predictor
      logic [31:0] brp_alt;       // the other path, used by EX on redirect
      logic        mispredicted;  // owned by EX; always 0 out of IF
   } rv32i_brp_word;

   // Default table geometry; the tag covers every PC bit above the index.
   localparam int BRP_IDX_BITS = 6;
   localparam int BRP_TAG_W    = 32 - BRP_IDX_BITS - 2;

   // Counter value for an empty entry: weak not-taken.
   localparam logic [1:0] BRP_CTR_INIT = 2'b01;

   // One BTB entry.
   typedef struct packed {
      logic                 valid;
      logic [BRP_TAG_W-1:0] tag;
      logic [31:0]          target;
      logic                 is_jump;
      logic [1:0]           ctr;     // 00 SNT, 01 WNT, 10 WT, 11 ST
   } brp_entry_t;

   // Saturating 2-bit counter step toward the resolved direction.
   function automatic logic [1:0] brp_ctr_step(input logic [1:0] ctr,
                                               input logic       taken);
      logic [1:0] nxt;
      nxt = ctr;
      if (taken && (ctr != 2'b11)) begin
         nxt = ctr + 2'b01;
      end else if (!taken && (ctr != 2'b00)) begin
         nxt = ctr - 2'b01;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// EX-stage resolution bus that trains the branch predictor.
// Handshake: there is no backpressure. ex_valid qualifies every other field
// for exactly the cycle it is high; the predictor always accepts, so there
// is no ready signal. The master (EX) drives, the slave (predictor) samples
// at the rising clock edge.
interface branch_predictor_if;
   logic        ex_valid;
   logic        ex_is_br;
   logic        ex_is_jump;
   logic [31:0] ex_pc;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        ex_mispredicted;

   modport master (
      output ex_valid, ex_is_br, ex_is_jump, ex_pc,
             ex_taken, ex_target, ex_mispredicted
   );

   modport slave (
      input  ex_valid, ex_is_br, ex_is_jump, ex_pc,
             ex_taken, ex_target, ex_mispredicted
   );
endinterface

// File: rtl/brp_table.sv
// Direct-mapped BTB storage: one combinational read port, one write port.
// The write port decides the new counter value itself, since only the table
// knows whether the write hits the currently stored tag.
module brp_table
   import rv32i_types::*;
#(
   parameter int IDX_BITS = BRP_IDX_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IDX_BITS-1:0]  rd_idx,
   output brp_entry_t           rd_entry,
   input  logic                 wr_en,
   input  logic [IDX_BITS-1:0]  wr_idx,
   input  logic [BRP_TAG_W-1:0] wr_tag,
   input  logic [31:0]          wr_target,
   input  logic                 wr_is_jump,
   input  logic                 wr_taken
);

   localparam int ENTRIES = 1 << IDX_BITS;

   localparam brp_entry_t ENTRY_RST = '{
      valid:   1'b0,
      tag:     '0,
      target:  32'h0,
      is_jump: 1'b0,
      ctr:     BRP_CTR_INIT
   };

   brp_entry_t entries_q [ENTRIES];
   brp_entry_t entries_d [ENTRIES];
   brp_entry_t wr_old;
   brp_entry_t wr_new;
   logic       wr_hit;

   // Read port: stored contents only, no bypass from a same-cycle write.
   always_comb begin
      rd_entry = entries_q[rd_idx];
   end

   // Build the entry being written; the counter depends on hit vs. replace.
   always_comb begin
      wr_old         = entries_q[wr_idx];
      wr_hit         = wr_old.valid && (wr_old.tag == wr_tag);
      wr_new         = wr_old;
      wr_new.valid   = 1'b1;
      wr_new.tag     = wr_tag;
      wr_new.target  = wr_target;
      wr_new.is_jump = wr_is_jump;
      if (wr_is_jump) begin
         wr_new.ctr = 2'b11;
      end else if (wr_hit) begin
         wr_new.ctr = brp_ctr_step(wr_old.ctr, wr_taken);
      end else begin
         wr_new.ctr = wr_taken ? 2'b10 : 2'b01;
      end
   end

   // Next-state of the array: only the written index changes.
   always_comb begin
      entries_d = entries_q;
      if (wr_en) begin
         entries_d[wr_idx] = wr_new;
      end
   end

   // Storage; reset clears every entry asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            entries_q[i] <= ENTRY_RST;
         end
      end else begin
         entries_q <= entries_d;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage dynamic branch predictor: direct-mapped BTB with 2-bit
// saturating direction counters, looked up combinationally with the IF PC
// and trained by EX on resolved branches and jumps.
// Optional build macro: BRP_STATS_EN adds the stat_ctrl / stat_mispred
// event counters and their ports.
module branch_predictor
   import rv32i_types::*;
#(
   parameter int IDX_BITS = BRP_IDX_BITS
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [31:0]        if_pc,
   output rv32i_brp_word      brp_o,
   branch_predictor_if.slave  ex
`ifdef BRP_STATS_EN
   ,
   output logic [31:0]        stat_ctrl,
   output logic [31:0]        stat_mispred
`endif
);

   logic [IDX_BITS-1:0]  if_idx;
   logic [BRP_TAG_W-1:0] if_tag;
   logic [IDX_BITS-1:0]  ex_idx;
   logic [BRP_TAG_W-1:0] ex_tag;
   logic [31:0]          pc_plus4;
   logic                 upd_en;
   logic                 hit;
   logic                 pred_taken;
   brp_entry_t           rd_entry;
   logic                 unused_bits;

   // Index/tag slicing for both ports and the update qualifier.
   always_comb begin
      if_idx   = if_pc[IDX_BITS+1:2];
      if_tag   = BRP_TAG_W'(if_pc >> (IDX_BITS + 2));
      ex_idx   = ex.ex_pc[IDX_BITS+1:2];
      ex_tag   = BRP_TAG_W'(ex.ex_pc >> (IDX_BITS + 2));
      upd_en   = ex.ex_valid && (ex.ex_is_br || ex.ex_is_jump);
   end

   // Byte-offset bits never affect lookup or training.
`ifdef BRP_STATS_EN
   assign unused_bits = ^{if_pc[1:0], ex.ex_pc[1:0]};
`else
   assign unused_bits = ^{if_pc[1:0], ex.ex_pc[1:0], ex.ex_mispredicted};
`endif

   brp_table #(
      .IDX_BITS (IDX_BITS)
   ) u_table (
      .clk        (clk),
      .rst        (rst),
      .rd_idx     (if_idx),
      .rd_entry   (rd_entry),
      .wr_en      (upd_en),
      .wr_idx     (ex_idx),
      .wr_tag     (ex_tag),
      .wr_target  (ex.ex_target),
      .wr_is_jump (ex.ex_is_jump),
      .wr_taken   (ex.ex_taken)
   );

   // Prediction word; jumps are always taken, branches follow ctr[1].
   always_comb begin
      pc_plus4   = if_pc + 32'd4;
      hit        = rd_entry.valid && (rd_entry.tag == if_tag);
      pred_taken = hit && (rd_entry.is_jump || rd_entry.ctr[1]);

      brp_o              = '0;
      brp_o.predicted    = hit;
      brp_o.prediction   = pred_taken;
      brp_o.brp_target   = pred_taken ? rd_entry.target : pc_plus4;
      brp_o.brp_alt      = pred_taken ? pc_plus4
                                      : (hit ? rd_entry.target : pc_plus4);
      brp_o.mispredicted = 1'b0;
   end

`ifdef BRP_STATS_EN
   logic [31:0] stat_ctrl_q,    stat_ctrl_d;
   logic [31:0] stat_mispred_q, stat_mispred_d;

   // Event counters; both wrap naturally at 2^32.
   always_comb begin
      stat_ctrl_d    = stat_ctrl_q;
      stat_mispred_d = stat_mispred_q;
      if (upd_en) begin
         stat_ctrl_d = stat_ctrl_q + 32'd1;
         if (ex.ex_mispredicted) begin
            stat_mispred_d = stat_mispred_q + 32'd1;
         end
      end
   end

   // Counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_ctrl_q    <= 32'h0;
         stat_mispred_q <= 32'h0;
      end else begin
         stat_ctrl_q    <= stat_ctrl_d;
         stat_mispred_q <= stat_mispred_d;
      end
   end

   assign stat_ctrl    = stat_ctrl_q;
   assign stat_mispred = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: a table of per-cycle vectors
// (EX update + IF lookup + expected prediction word), followed by
// hand-written reset and statistics sequences.
module tb_branch_predictor;
   import rv32i_types::*;

   localparam int W = 67;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst;
   logic [31:0] if_pc;
   rv32i_brp_word brp_o;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   branch_predictor_if ex_if ();

`ifdef BRP_STATS_EN
   logic [31:0] stat_ctrl;
   logic [31:0] stat_mispred;
`endif

   branch_predictor #(
      .IDX_BITS (6)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .if_pc (if_pc),
      .brp_o (brp_o),
      .ex    (ex_if)
`ifdef BRP_STATS_EN
      ,
      .stat_ctrl    (stat_ctrl),
      .stat_mispred (stat_mispred)
`endif
   );

   // ---------------- scoreboard ----------------
   int total;
   int bad;
   logic [W-1:0] exp_q[$];

   typedef struct {
      logic        v;
      logic        br;
      logic        jmp;
      logic [31:0] pc;
      logic        taken;
      logic [31:0] tgt;
      logic [31:0] lpc;
      logic        h;
      logic        p;
      logic [31:0] et;
      logic [31:0] ea;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mkv(input logic v, input logic br, input logic jmp,
                                input logic [31:0] pc, input logic taken,
                                input logic [31:0] tgt, input logic [31:0] lpc,
                                input logic h, input logic p,
                                input logic [31:0] et, input logic [31:0] ea);
      vec_t r;
      r.v = v; r.br = br; r.jmp = jmp; r.pc = pc; r.taken = taken;
      r.tgt = tgt; r.lpc = lpc; r.h = h; r.p = p; r.et = et; r.ea = ea;
      return r;
   endfunction

   function automatic logic [W-1:0] mkw(input logic h, input logic p,
                                        input logic [31:0] et,
                                        input logic [31:0] ea);
      return {h, p, et, ea, 1'b0};
   endfunction

   task automatic chk(input string name, input logic [W-1:0] got,
                      input logic [W-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_ex(input logic v, input logic br, input logic jmp,
                           input logic [31:0] pc, input logic taken,
                           input logic [31:0] tgt, input logic mis);
      ex_if.ex_valid        = v;
      ex_if.ex_is_br        = br;
      ex_if.ex_is_jump      = jmp;
      ex_if.ex_pc           = pc;
      ex_if.ex_taken        = taken;
      ex_if.ex_target       = tgt;
      ex_if.ex_mispredicted = mis;
   endtask

   task automatic idle_ex();
      drive_ex(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
   endtask

   // One table row: drive after the edge, check the lookup at the falling
   // edge (before this row's update is committed).
   task automatic apply_vec(input int i, input vec_t t);
      logic [W-1:0] e;
      @(posedge clk);
      #1;
      drive_ex(t.v, t.br, t.jmp, t.pc, t.taken, t.tgt, 1'b0);
      if_pc = t.lpc;
      exp_q.push_back(mkw(t.h, t.p, t.et, t.ea));
      @(negedge clk);
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL row%0d: got empty queue expected an entry", i);
      end else begin
         e = exp_q.pop_front();
         chk($sformatf("row%0d", i), brp_o, e);
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      if_pc = 32'h100;
      idle_ex();

      // Row table. Index 0 is shared by 0x100/0x200/0x300/0x400 (IDX_BITS=6).
      // reset state
      vecs.push_back(mkv(0,0,0, 32'h0,  0, 32'h0,   32'h100, 0,0, 32'h104, 32'h104));
      // branch 0x100 taken -> 0x80; same-cycle lookup still misses
      vecs.push_back(mkv(1,1,0, 32'h100,1, 32'h80,  32'h100, 0,0, 32'h104, 32'h104));
      vecs.push_back(mkv(0,0,0, 32'h0,  0, 32'h0,   32'h100, 1,1, 32'h80,  32'h104));
      // two not-taken: same-cycle shows old ctr 10, then 01, then 00
      vecs.push_back(mkv(1,1,0, 32'h100,0, 32'h80,  32'h100, 1,1, 32'h80,  32'h104));
      vecs.push_back(mkv(1,1,0, 32'h100,0, 32'h80,  32'h100, 1,0, 32'h104, 32'h80));
      vecs.push_back(mkv(0,0,0, 32'h0,  0, 32'h0,   32'h100, 1,0, 32'h104, 32'h80));
      // four taken -> saturate at 11; lookup an empty neighbour meanwhile
      for (int k = 0; k < 4; k++) begin
         vecs.push_back(mkv(1,1,0, 32'h100,1, 32'h80, 32'h104, 0,0, 32'h108, 32'h108));
      end
      // not-taken twice: 11 -> 10 (still taken) -> 01 (not taken)
      vecs.push_back(mkv(1,1,0, 32'h100,0, 32'h80,  32'h100, 1,1, 32'h80,  32'h104));
      vecs.push_back(mkv(0,0,0, 32'h0,  0, 32'h0,   32'h100, 1,1, 32'h80,  32'h104));
      vecs.push_back(mkv(1,1,0, 32'h100,0, 32'h80,  32'h100, 1,1, 32'h80,  32'h104));
      vecs.push_back(mkv(0,0,0, 32'h0,  0, 32'h0,   32'h100, 1,0, 32'h104, 32'h80));
      // jal 0x200 -> 0x400 replaces 0x100
      vecs.push_back(mkv(1,0,1, 32'h200,1, 32'h400, 32'h200, 0,0, 32'h204, 32'h204));
      vecs.push_back(mkv(0,0,0, 32'h0,  0, 32'h0,   32'h200, 1,1, 32'h400, 32'h204));
      vecs.push_back(mkv(0,0,0, 32'h0,  0, 32'h0,   32'h100, 0,0, 32'h104, 32'h104));
      // alias: branch 0x300 not-taken replaces jump, ctr 01
      vecs.push_back(mkv(1,1,0, 32'h300,0, 32'h500, 32'h300, 0,0, 32'h304, 32'h304));
      vecs.push_back(mkv(0,0,0, 32'h0,  0, 32'h0,   32'h300, 1,0, 32'h304, 32'h500));
      vecs.push_back(mkv(0,0,0, 32'h0,  0, 32'h0,   32'h200, 0,0, 32'h204, 32'h204));
      // jump on a hit forces ctr 11; a later not-taken branch leaves 10
      vecs.push_back(mkv(1,0,1, 32'h300,1, 32'h600, 32'h304, 0,0, 32'h308, 32'h308));
      vecs.push_back(mkv(1,1,0, 32'h300,0, 32'h600, 32'h300, 1,1, 32'h600, 32'h304));
      vecs.push_back(mkv(0,0,0, 32'h0,  0, 32'h0,   32'h300, 1,1, 32'h600, 32'h304));
      // ex_valid low: ignored
      vecs.push_back(mkv(0,1,0, 32'h300,1, 32'h700, 32'h300, 1,1, 32'h600, 32'h304));
      vecs.push_back(mkv(0,0,0, 32'h0,  0, 32'h0,   32'h300, 1,1, 32'h600, 32'h304));
      // valid but no type flag: ignored
      vecs.push_back(mkv(1,0,0, 32'h300,1, 32'h700, 32'h300, 1,1, 32'h600, 32'h304));
      vecs.push_back(mkv(0,0,0, 32'h0,  0, 32'h0,   32'h300, 1,1, 32'h600, 32'h304));
      // both flags: jump wins even with ex_taken=0
      vecs.push_back(mkv(1,1,1, 32'h400,0, 32'h900, 32'h400, 0,0, 32'h404, 32'h404));
      vecs.push_back(mkv(0,0,0, 32'h0,  0, 32'h0,   32'h400, 1,1, 32'h900, 32'h404));
      // PC wrap at the top of the address space
      vecs.push_back(mkv(1,0,1, 32'hFFFF_FFFC,1, 32'h10, 32'hFFFF_FFFC, 0,0, 32'h0, 32'h0));
      vecs.push_back(mkv(0,0,0, 32'h0,  0, 32'h0,   32'hFFFF_FFFC, 1,1, 32'h10, 32'h0));

      repeat (2) @(posedge clk);
      #1;
`ifdef BRP_STATS_EN
      chk("stat_ctrl_rst", {35'h0, stat_ctrl}, {W{1'b0}});
      chk("stat_mispred_rst", {35'h0, stat_mispred}, {W{1'b0}});
`endif
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         apply_vec(i, vecs[i]);
      end

      // ---------- asynchronous reset mid-run ----------
      @(posedge clk);
      #1;
      idle_ex();
      if_pc = 32'h400;
      @(negedge clk);
      chk("pre_rst", brp_o, mkw(1, 1, 32'h900, 32'h404));
      #1 rst = 1'b1;
      #1 chk("rst_async", brp_o, mkw(0, 0, 32'h404, 32'h404));
      // update coincident with reset must be dropped
      drive_ex(1'b1, 1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0);
      if_pc = 32'h100;
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle_ex();
      @(negedge clk);
      chk("rst_drop", brp_o, mkw(0, 0, 32'h104, 32'h104));

`ifdef BRP_STATS_EN
      // ---------- statistics ----------
      @(posedge clk); #1; drive_ex(1, 1, 0, 32'h100, 1, 32'h80,  1);
      @(posedge clk); #1; drive_ex(1, 0, 1, 32'h200, 1, 32'h400, 0);
      @(posedge clk); #1; drive_ex(1, 1, 0, 32'h104, 0, 32'h40,  0);
      @(posedge clk); #1; drive_ex(0, 1, 0, 32'h100, 1, 32'h80,  1);
      @(posedge clk); #1; drive_ex(1, 0, 0, 32'h100, 1, 32'h80,  1);
      @(posedge clk); #1; drive_ex(1, 1, 0, 32'h100, 0, 32'h80,  1);
      @(posedge clk); #1; drive_ex(1, 0, 1, 32'h300, 1, 32'h600, 0);
      @(posedge clk); #1; idle_ex();
      @(negedge clk);
      chk("stat_ctrl", {35'h0, stat_ctrl}, {35'h0, 32'd5});
      chk("stat_mispred", {35'h0, stat_mispred}, {35'h0, 32'd2});
      #1 rst = 1'b1;
      #1;
      chk("stat_ctrl_async", {35'h0, stat_ctrl}, {W{1'b0}});
      chk("stat_mispred_async", {35'h0, stat_mispred}, {W{1'b0}});
      @(posedge clk);
      #1 rst = 1'b0;
`endif

      // ---------- report ----------
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL sb_drain: got %0d entries expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
